// File: rtl/count_sequencer.sv
// count_sequencer: command-driven control for the 4-bit step counter.
// Optional midpoint early-stop is enabled by COUNT_SEQ_MIDSTOP_EN.
module count_sequencer #(
  parameter int LEN_W = 8
) (
  input  logic             i_Clock,
  input  logic             i_Reset,
  input  logic             i_CmdValid,
  output logic             o_CmdReady,
  input  logic [1:0]       i_CmdOp,
  input  logic [3:0]       i_CmdStep,
  input  logic [LEN_W-1:0] i_CmdLen,
  input  logic             i_CmdStopMid,
  input  logic             i_AtMidpoint,
  output logic             o_InializeCount,
  output logic             o_CountUp,
  output logic             o_EnableCount,
  output logic [3:0]       o_N,
  output logic             o_Busy,
  output logic             o_Done,
  output logic             o_MidStop
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_INIT = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_e;

  localparam logic [1:0] OP_INIT = 2'b00;
  localparam logic [1:0] OP_UP   = 2'b01;
  localparam logic [1:0] OP_DOWN = 2'b10;
  localparam logic [1:0] OP_HOLD = 2'b11;

  state_e           state_q, state_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic             ready_q, ready_d;
  logic             init_q, init_d;
  logic             up_q, up_d;
  logic             en_q, en_d;
  logic [3:0]       n_q, n_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             accept;
  logic             mid_hit;

  assign accept = i_CmdValid & ready_q;

`ifdef COUNT_SEQ_MIDSTOP_EN
  logic stop_q;
  logic mids_q, mids_d;

  assign mid_hit = stop_q & i_AtMidpoint;

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      stop_q <= 1'b0;
      mids_q <= 1'b0;
    end else begin
      if (accept && state_q == S_IDLE) stop_q <= i_CmdStopMid;
      mids_q <= mids_d;
    end
  end

  assign o_MidStop = mids_q;
`else
  logic unused_mid;

  assign unused_mid = i_CmdStopMid ^ i_AtMidpoint;
  assign mid_hit    = 1'b0;
  assign o_MidStop  = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    ready_d = 1'b0;
    en_d    = 1'b0;
    up_d    = up_q;
    n_d     = n_q;
`ifdef COUNT_SEQ_MIDSTOP_EN
    mids_d  = mids_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        ready_d = 1'b1;
        if (accept) begin
          ready_d = 1'b0;
          n_d     = i_CmdStep;
`ifdef COUNT_SEQ_MIDSTOP_EN
          mids_d  = 1'b0;
`endif
          if (i_CmdOp == OP_INIT) begin
            state_d = S_INIT;
          end else if (i_CmdLen == '0) begin
            state_d = S_DONE;
          end else begin
            state_d = S_RUN;
            rem_d   = i_CmdLen;
            en_d    = (i_CmdOp != OP_HOLD);
            if (i_CmdOp == OP_UP)   up_d = 1'b1;
            if (i_CmdOp == OP_DOWN) up_d = 1'b0;
          end
        end
      end
      S_INIT: begin
        state_d = S_DONE;
      end
      S_RUN: begin
        en_d = en_q;
        if (mid_hit) begin
          state_d = S_DONE;
          en_d    = 1'b0;
`ifdef COUNT_SEQ_MIDSTOP_EN
          mids_d  = 1'b1;
`endif
        end else if (rem_q == LEN_W'(1)) begin
          state_d = S_DONE;
          en_d    = 1'b0;
        end else begin
          rem_d = rem_q - LEN_W'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        ready_d = 1'b1;
      end
    endcase
    init_d = (state_d == S_INIT);
    done_d = (state_d == S_DONE);
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      state_q <= S_IDLE;
      rem_q   <= '0;
      ready_q <= 1'b0;
      init_q  <= 1'b0;
      up_q    <= 1'b0;
      en_q    <= 1'b0;
      n_q     <= 4'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      ready_q <= ready_d;
      init_q  <= init_d;
      up_q    <= up_d;
      en_q    <= en_d;
      n_q     <= n_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign o_CmdReady      = ready_q;
  assign o_InializeCount = init_q;
  assign o_CountUp       = up_q;
  assign o_EnableCount   = en_q;
  assign o_N             = n_q;
  assign o_Busy          = busy_q;
  assign o_Done          = done_q;

endmodule

// File: tb/tb_count_sequencer.sv
// tb_count_sequencer: directed vectors for count_sequencer.
// Midpoint expectations follow COUNT_SEQ_MIDSTOP_EN.
module tb_count_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       valid;
  logic       ready;
  logic [1:0] op;
  logic [3:0] step;
  logic [7:0] len;
  logic       stopmid;
  logic       atmid;
  logic       init;
  logic       up;
  logic       en;
  logic [3:0] n;
  logic       busy;
  logic       done;
  logic       midstop;

  int vectors = 0;
  int fails   = 0;
  int cnt;
  int dcnt;
  int exp_en;
  logic exp_ms;

  count_sequencer #(.LEN_W(8)) dut (
    .i_Clock        (clk),
    .i_Reset        (rst),
    .i_CmdValid     (valid),
    .o_CmdReady     (ready),
    .i_CmdOp        (op),
    .i_CmdStep      (step),
    .i_CmdLen       (len),
    .i_CmdStopMid   (stopmid),
    .i_AtMidpoint   (atmid),
    .o_InializeCount(init),
    .o_CountUp      (up),
    .o_EnableCount  (en),
    .o_N            (n),
    .o_Busy         (busy),
    .o_Done         (done),
    .o_MidStop      (midstop)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] o, input logic [3:0] s,
                       input logic [7:0] l, input logic sm);
    valid   = 1'b1;
    op      = o;
    step    = s;
    len     = l;
    stopmid = sm;
    tick();
    valid   = 1'b0;
  endtask

  initial begin
    rst = 1'b1; valid = 1'b0; op = 2'b00; step = 4'd0;
    len = 8'd0; stopmid = 1'b0; atmid = 1'b0;
    #20;
    chk("rst_outs", {ready, init, up, en, n, busy, done, midstop}, 0);
    #2 rst = 1'b0;
    #1 chk("rst_ready_low", ready, 0);
    tick();
    chk("rel_ready", ready, 1);

    issue(2'b10, 4'd2, 8'd0, 1'b0);
    chk("d0_done", done, 1);
    chk("d0_en", en, 0);
    chk("d0_up", up, 0);
    chk("d0_busy", busy, 1);
    tick();
    chk("d0_done_end", done, 0);
    chk("d0_ready", ready, 1);

    issue(2'b01, 4'd3, 8'd4, 1'b0);
    chk("up_n", n, 3);
    chk("up_dir", up, 1);
    chk("up_ready", ready, 0);
    cnt = 0;
    for (int i = 0; i < 4; i++) begin
      if (en === 1'b1 && done === 1'b0) cnt++;
      tick();
    end
    chk("up_encnt", cnt, 4);
    chk("up_en_off", en, 0);
    chk("up_done", done, 1);
    tick();
    chk("up_done_end", done, 0);
    chk("up_ready2", ready, 1);
    chk("up_busy", busy, 0);

    issue(2'b00, 4'd5, 8'd9, 1'b0);
    chk("in_init", init, 1);
    chk("in_n", n, 5);
    chk("in_en", en, 0);
    chk("in_done0", done, 0);
    tick();
    chk("in_init_off", init, 0);
    chk("in_done", done, 1);
    chk("in_en2", en, 0);
    tick();
    chk("in_ready", ready, 1);

    issue(2'b11, 4'd1, 8'd3, 1'b0);
    chk("hd_en", en, 0);
    chk("hd_up", up, 1);
    chk("hd_busy", busy, 1);
    tick();
    tick();
    chk("hd_done0", done, 0);
    tick();
    chk("hd_done", done, 1);
    tick();
    chk("hd_ready", ready, 1);

    issue(2'b01, 4'd1, 8'd20, 1'b1);
    cnt = 0;
    dcnt = 0;
    for (int c = 0; c < 40; c++) begin
      if (done === 1'b1) begin
        dcnt++;
        break;
      end
      if (en === 1'b1) cnt++;
      if (c == 5) atmid = 1'b1;
      if (c == 6) atmid = 1'b0;
      tick();
    end
    atmid = 1'b0;
`ifdef COUNT_SEQ_MIDSTOP_EN
    exp_en = 6;
    exp_ms = 1'b1;
`else
    exp_en = 20;
    exp_ms = 1'b0;
`endif
    chk("ms_done_seen", dcnt, 1);
    chk("ms_encnt", cnt, exp_en);
    chk("ms_flag", midstop, exp_ms);
    tick();
    chk("ms_ready", ready, 1);
    chk("ms_flag_hold", midstop, exp_ms);

    issue(2'b01, 4'd4, 8'd10, 1'b0);
    chk("mr_en", en, 1);
    chk("mr_ms_clr", midstop, 0);
    tick();
    tick();
    tick();
    chk("mr_en4", en, 1);
    #2 rst = 1'b1;
    #1;
    chk("mr_en_drop", en, 0);
    chk("mr_busy", busy, 0);
    chk("mr_done", done, 0);
    #1 rst = 1'b0;
    tick();
    chk("mr_done2", done, 0);
    chk("mr_ready", ready, 1);
    issue(2'b01, 4'd7, 8'd1, 1'b0);
    chk("mr_new_en", en, 1);
    chk("mr_new_n", n, 7);
    tick();
    chk("mr_new_done", done, 1);
    chk("mr_new_en_off", en, 0);
    tick();
    chk("mr_new_ready", ready, 1);

    issue(2'b01, 4'd2, 8'd2, 1'b0);
    valid = 1'b1;
    op = 2'b00;
    step = 4'd9;
    tick();
    tick();
    chk("ig_done", done, 1);
    chk("ig_init", init, 0);
    chk("ig_n", n, 2);
    valid = 1'b0;
    tick();
    chk("ig_ready", ready, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule

// File: doc/count_sequencer.md
# count_sequencer

Command-driven control sequencer that sits directly upstream of the 4-bit step counter. It accepts one command at a time over a valid/ready handshake and drives the counter's initialize, direction, enable and step-size lines for a programmed number of cycles. It watches the counter's midpoint flag so a run can optionally end early. All outputs are registered.

## Interface
- LEN_W, default 8: width of the run-length field and of the internal remaining-cycles counter.

- i$Clock  input  1  single clock; all logic on rising edge.
- i$Reset  input  1  asynchronous, active-high reset.
- i$CmdValid  input  1  command present; held with fields stable until accepted.
- o$CmdReady  output  1  sequencer can accept a command this cycle.
- i$CmdOp  input  2  00 INIT, 01 UP, 10 DOWN, 11 HOLD.
- i$CmdStep  input  4  step size forwarded to the counter.
- i$CmdLen  input  LEN_W  run length in cycles (UP/DOWN/HOLD).
- i$CmdStopMid  input  1  end run when the midpoint is reached.
- i$AtMidpoint  input  1  midpoint flag from the counter.
- o$InializeCount  output  1  counter initialize strobe.
- o$CountUp  output  1  counter direction (1 = up).
- o$EnableCount  output  1  counter enable.
- o$N  output  4  counter step size.
- o$Busy  output  1  command in progress (state ≠ IDLE).
- o$Done  output  1  one-cycle completion pulse.
- o$MidStop  output  1  last run ended on midpoint; cleared on next acceptance.

## Operation
- States: IDLE, INIT, RUN, DONE.
- Accept: `i$CmdValid & o$CmdReady` at a rising edge. Latch op, step, len and stopmid. Set o$N = step. Clear o$MidStop.
- On accept:
  - op=INIT → INIT.
  - Otherwise, len=0 → DONE.
  - Otherwise → RUN with remaining = len.
- INIT: o$InializeCount=1 for exactly one cycle, then → DONE. o$EnableCount stays 0.
- RUN:
  - o$EnableCount=1 for UP/DOWN and 0 for HOLD.
  - o$CountUp=1 for UP, 0 for DOWN, unchanged for HOLD.
  - remaining decrements every cycle. At remaining=1 → DONE.
- Midpoint stop: in RUN with stopmid=1, if i$AtMidpoint=1 is sampled at an edge → DONE at that edge and o$MidStop←1. If this coincides with remaining=1, the result is the same: DONE with o$MidStop=1.
- DONE: o$Done=1 for one cycle, o$CmdReady=0, then → IDLE.
- o$CmdReady=1 only in IDLE.
- CmdValid while not ready is ignored; there is no queuing.
- o$N and o$CountUp hold their last values in IDLE.
- o$InializeCount and o$EnableCount are 0 in all states other than the ones stated above.
- Illegal or unused encodings: none. All 2-bit ops are defined.

## Timing
- Reset values (applied immediately on i$Reset, independent of the clock): state IDLE, and all outputs 0, including o$CmdReady. o$CmdReady rises on the first rising edge after i$Reset deasserts.
- Command accepted at edge k:
  - o$EnableCount is high from edge k to edge k+len (exactly len cycles).
  - o$Done is high for the cycle starting at edge k+len.
  - o$CmdReady is high again at edge k+len+1.
- INIT accepted at edge k: o$InializeCount is high for [k, k+1), o$Done for [k+1, k+2).
- len=0: o$Done for [k, k+1) and no enable cycles.
- Midpoint sampled high at the edge ending run cycle m: exactly m enable cycles, then o$Done for one cycle.
- Minimum command spacing: len+2 cycles for runs, 3 cycles for INIT.
- Reset mid-operation: the command is abandoned and no o$Done is issued. o$EnableCount and o$InializeCount drop asynchronously.

## Configuration
- Macro: COUNT_SEQ_MIDSTOP_EN.
- Defined: midpoint early-stop and o$MidStop behave as described above.
- Undefined:
  - i$CmdStopMid and i$AtMidpoint are ignored; runs always last len cycles.
  - o$MidStop is tied to 0.
  - No midpoint logic is synthesized.

## Test plan
- Reset: hold i$Reset for 20 ns → all outputs 0. o$CmdReady=1 one cycle after release.
- UP, step=3, len=4 → o$EnableCount high for exactly 4 cycles with o$CountUp=1 and o$N=3. o$Done pulses once on the 5th cycle. o$CmdReady returns on the 6th.
- INIT, step=5 → o$InializeCount high for one cycle with o$N=5. o$EnableCount never rises. o$Done on the next cycle.
- DOWN, len=0 → no enable cycles. o$Done in the cycle right after acceptance. o$CountUp stays 0.
- With COUNT_SEQ_MIDSTOP_EN: UP, len=20, stopmid=1, i$AtMidpoint high during run cycle 6 → exactly 6 enable cycles and o$MidStop=1. Without the macro → 20 enable cycles and o$MidStop=0.
- UP, len=10, i$Reset asserted mid-cycle during run cycle 4 → o$EnableCount drops before the next edge. No o$Done. The sequencer accepts a new command after release.
